regfile_write_arbiter: RTL and testbench

- Owns the single write port of the register file (W-bit, 2**A entries) and shares it between the core writeback path and an auxiliary requester (debug/load unit) with valid/ready handshake.
- After reset, runs an init sweep that writes INIT_VAL to every register before normal operation starts.
- Core has priority. A saturating wait counter guarantees the aux requester is served within MAX_WAIT+1 cycles.
- Sits between the writeback stage and the register file. Drives the file's RegWrite/RegDest/Waddr/DataIn.

---
 rtl/regfile_arb_pkg.sv | 19 +
 rtl/regfile_write_arbiter_if.sv | 36 +++
 rtl/sat_counter.sv | 36 +++
 rtl/regfile_write_arbiter.sv | 114 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types for the register file write arbiter.
// Imported by the arbiter top and its interface users.
package regfile_arb_pkg;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_INIT,
      GNT_CORE,
      GNT_AUX
   } gnt_e;

   localparam logic [1:0] REGDEST_REG = 2'b00;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Core, aux and register file write-port bundle.
// The arbiter is the slave; requesters and the file sit on master.
interface regfile_write_arbiter_if #(
   parameter int unsigned W = 8,
   parameter int unsigned A = 3
);
   logic         CoreWe;
   logic [1:0]   CoreRegDest;
   logic [A-1:0] CoreWaddr;
   logic [W-1:0] CoreWdata;
   logic         CoreStall;
   logic         AuxValid;
   logic [A-1:0] AuxWaddr;
   logic [W-1:0] AuxWdata;
   logic         AuxReady;
   logic         InitBusy;
   logic         RegWrite;
   logic [1:0]   RegDest;
   logic [A-1:0] Waddr;
   logic [W-1:0] DataIn;

   modport slave (
      input  CoreWe, CoreRegDest, CoreWaddr, CoreWdata,
      input  AuxValid, AuxWaddr, AuxWdata,
      output CoreStall, AuxReady, InitBusy,
      output RegWrite, RegDest, Waddr, DataIn
   );

   modport master (
      output CoreWe, CoreRegDest, CoreWaddr, CoreWdata,
      output AuxValid, AuxWaddr, AuxWdata,
      input  CoreStall, AuxReady, InitBusy,
      input  RegWrite, RegDest, Waddr, DataIn
   );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins).
module sat_counter #(
   parameter int unsigned MAX = 3,
   parameter int unsigned CW  = $clog2(MAX + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          inc_i,
   input  logic          clr_i,
   output logic [CW-1:0] count_o
);
   localparam logic [CW-1:0] TOP = CW'(MAX);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (inc_i && (count_q != TOP)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register file write-port owner: init sweep, then core-priority
// arbitration with a starvation bound for the aux requester.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned  W        = 8,
   parameter int unsigned  A        = 3,
   parameter logic [W-1:0] INIT_VAL = '0,
   parameter int unsigned  MAX_WAIT = 3
) (
   input logic Clk,
   input logic Reset_n,
   regfile_write_arbiter_if.slave bus
);
   localparam int unsigned   CW       = $clog2(MAX_WAIT + 1);
   localparam logic [A-1:0]  PTR_LAST = '1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

   state_e        state_q, state_d;
   logic [A-1:0]  ptr_q, ptr_d;
   logic [CW-1:0] cnt;
   logic          starve;
   logic          cnt_inc;
   logic          cnt_clr;
   gnt_e          gnt;

   assign starve = bus.AuxValid && (cnt == CNT_MAX);

   always_comb begin
      gnt = GNT_NONE;
      priority case (1'b1)
         (state_q == INIT): gnt = GNT_INIT;
         starve:            gnt = GNT_AUX;
         bus.CoreWe:        gnt = GNT_CORE;
         bus.AuxValid:      gnt = GNT_AUX;
         default:           gnt = GNT_NONE;
      endcase
   end

   assign cnt_inc = (gnt == GNT_CORE) && bus.AuxValid;
   assign cnt_clr = (gnt == GNT_AUX);

   sat_counter #(
      .MAX (MAX_WAIT),
      .CW  (CW)
   ) u_wait (
      .clk_i   (Clk),
      .rst_ni  (Reset_n),
      .inc_i   (cnt_inc),
      .clr_i   (cnt_clr),
      .count_o (cnt)
   );

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      if (state_q == INIT) begin
         ptr_d = ptr_q + 1'b1;
         if (ptr_q == PTR_LAST) begin
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Reset gates the outputs so the file write drops without a clock.
   always_comb begin
      bus.RegWrite  = 1'b0;
      bus.RegDest   = REGDEST_REG;
      bus.Waddr     = '0;
      bus.DataIn    = '0;
      bus.CoreStall = 1'b0;
      bus.AuxReady  = 1'b0;
      bus.InitBusy  = 1'b0;
      if (!Reset_n) begin
         bus.CoreStall = 1'b1;
         bus.InitBusy  = 1'b1;
      end else begin
         unique case (gnt)
            GNT_INIT: begin
               bus.RegWrite  = 1'b1;
               bus.Waddr     = ptr_q;
               bus.DataIn    = INIT_VAL;
               bus.CoreStall = 1'b1;
               bus.InitBusy  = 1'b1;
            end
            GNT_CORE: begin
               bus.RegWrite = 1'b1;
               bus.RegDest  = bus.CoreRegDest;
               bus.Waddr    = bus.CoreWaddr;
               bus.DataIn   = bus.CoreWdata;
            end
            GNT_AUX: begin
               bus.RegWrite  = 1'b1;
               bus.Waddr     = bus.AuxWaddr;
               bus.DataIn    = bus.AuxWdata;
               bus.AuxReady  = 1'b1;
               bus.CoreStall = starve;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: vector table plus scoreboard
// of expected port values popped on every falling clock edge.
module tb_regfile_write_arbiter;

   typedef struct packed {
      logic       rw;
      logic [1:0] rd;
      logic [2:0] wa;
      logic [7:0] di;
      logic       stall;
      logic       ardy;
      logic       busy;
   } out_t;

   typedef struct {
      logic       cwe;
      logic [1:0] crd;
      logic [2:0] ca;
      logic [7:0] cd;
      logic       av;
      logic [2:0] aa;
      logic [7:0] ad;
      out_t       e;
      string      nm;
   } vec_t;

   typedef struct {
      out_t  e;
      string nm;
   } sb_t;

   logic Clk;
   logic Reset_n;
   int   n_checks;
   int   n_fail;
   sb_t  sb[$];
   sb_t  cur_sb;
   logic pend;
   logic [7:0] mem [8];
   vec_t tbl [7];

   regfile_write_arbiter_if #(.W(8), .A(3)) bus ();

   regfile_write_arbiter #(
      .W        (8),
      .A        (3),
      .INIT_VAL (8'h00),
      .MAX_WAIT (3)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: no end of test by time limit");
      $fatal(1, "timeout");
   end

   // Register file model; poisoned during reset so the sweep is visible.
   always @(posedge Clk) begin
      if (!Reset_n) begin
         for (int k = 0; k < 8; k++) mem[k] <= 8'hFF;
      end else if (bus.RegWrite) begin
         mem[bus.Waddr] <= bus.DataIn;
      end
   end

   function automatic out_t mk(
      input logic rw, input logic [1:0] rd,
      input logic [2:0] wa, input logic [7:0] di,
      input logic stall, input logic ardy,
      input logic busy);
      out_t o;
      o = {rw, rd, wa, di, stall, ardy, busy};
      return o;
   endfunction

   function automatic out_t cur();
      out_t o;
      o = {bus.RegWrite, bus.RegDest, bus.Waddr,
           bus.DataIn, bus.CoreStall, bus.AuxReady,
           bus.InitBusy};
      return o;
   endfunction

   function automatic vec_t vec(
      input logic cwe, input logic [1:0] crd,
      input logic [2:0] ca, input logic [7:0] cd,
      input logic av, input logic [2:0] aa,
      input logic [7:0] ad, input out_t e,
      input string nm);
      vec_t v;
      v.cwe = cwe; v.crd = crd; v.ca = ca; v.cd = cd;
      v.av = av; v.aa = aa; v.ad = ad;
      v.e = e; v.nm = nm;
      return v;
   endfunction

   task automatic chk(input string nm, input out_t g,
                      input out_t e);
      n_checks++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)",
                  nm, g, e, $time);
      end
   endtask

   task automatic chk8(input string nm, input logic [7:0] g,
                       input logic [7:0] e);
      n_checks++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, g, e);
      end
   endtask

   task automatic push(input out_t e, input string nm);
      sb_t t;
      t.e  = e;
      t.nm = nm;
      sb.push_back(t);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      bus.CoreWe      = v.cwe;
      bus.CoreRegDest = v.crd;
      bus.CoreWaddr   = v.ca;
      bus.CoreWdata   = v.cd;
      bus.AuxValid    = v.av;
      bus.AuxWaddr    = v.aa;
      bus.AuxWdata    = v.ad;
   endtask

   task automatic apply(input vec_t v);
      drive(v);
      push(v.e, v.nm);
      tick();
   endtask

   task automatic sweep(input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         push(mk(1'b1, 2'b00, 3'(i), 8'h00,
                 1'b1, 1'b0, 1'b1), nm);
         tick();
      end
   endtask

   // Scoreboard pop plus aux handshake protocol watch.
   always @(negedge Clk) begin
      if (sb.size() != 0) begin
         cur_sb = sb.pop_front();
         chk(cur_sb.nm, cur(), cur_sb.e);
      end
      if (Reset_n && pend && !bus.AuxValid)
         $error("aux request withdrawn without transfer");
      pend = Reset_n && bus.AuxValid && !bus.AuxReady;
   end

   out_t idle_o;
   out_t rst_o;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      pend     = 1'b0;
      idle_o   = mk(1'b0, 2'b00, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      rst_o    = mk(1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1);

      tbl[0] = vec(1'b1, 2'b01, 3'd5, 8'hA7, 1'b0, 3'd0, 8'h00,
         mk(1'b1, 2'b01, 3'd5, 8'hA7, 1'b0, 1'b0, 1'b0), "core_wr");
      tbl[1] = vec(1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 3'd2, 8'h3C,
         mk(1'b1, 2'b00, 3'd2, 8'h3C, 1'b0, 1'b1, 1'b0), "aux_wr");
      tbl[2] = vec(1'b0, 2'b11, 3'd7, 8'h55, 1'b0, 3'd6, 8'h66,
         idle_o, "idle");
      tbl[3] = vec(1'b1, 2'b10, 3'd1, 8'h11, 1'b1, 3'd4, 8'h44,
         mk(1'b1, 2'b10, 3'd1, 8'h11, 1'b0, 1'b0, 1'b0), "both_core");
      tbl[4] = vec(1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 3'd4, 8'h44,
         mk(1'b1, 2'b00, 3'd4, 8'h44, 1'b0, 1'b1, 1'b0), "aux_after");
      tbl[5] = vec(1'b1, 2'b11, 3'd7, 8'hFE, 1'b0, 3'd0, 8'h00,
         mk(1'b1, 2'b11, 3'd7, 8'hFE, 1'b0, 1'b0, 1'b0), "core_rd11");
      tbl[6] = vec(1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 3'd0, 8'h81,
         mk(1'b1, 2'b00, 3'd0, 8'h81, 1'b0, 1'b1, 1'b0), "aux_a0");

      // Reset held with a core request present: outputs forced safe.
      Reset_n = 1'b0;
      drive(tbl[0]);
      #3;
      chk("reset_hold", cur(), rst_o);

      tick();
      Reset_n = 1'b1;
      sweep(8, "init_sweep");

      n_checks++;
      for (int k = 0; k < 8; k++) begin
         if (mem[k] !== 8'h00) begin
            n_fail++;
            $display("FAIL init_mem[%0d]: got %h expected 00",
                     k, mem[k]);
            break;
         end
      end

      for (int i = 0; i < 7; i++) apply(tbl[i]);

      // Starvation bound: core every cycle, aux waits MAX_WAIT cycles.
      for (int i = 0; i < 3; i++) begin
         apply(vec(1'b1, 2'b01, 3'd3, 8'hC0 + 8'(i),
                   1'b1, 3'd6, 8'h99,
                   mk(1'b1, 2'b01, 3'd3, 8'hC0 + 8'(i),
                      1'b0, 1'b0, 1'b0), "starve_core"));
      end
      apply(vec(1'b1, 2'b01, 3'd3, 8'hC3, 1'b1, 3'd6, 8'h99,
         mk(1'b1, 2'b00, 3'd6, 8'h99, 1'b1, 1'b1, 1'b0),
         "starve_aux"));
      apply(vec(1'b1, 2'b01, 3'd3, 8'hC3, 1'b0, 3'd0, 8'h00,
         mk(1'b1, 2'b01, 3'd3, 8'hC3, 1'b0, 1'b0, 1'b0),
         "starve_core_held"));
      apply(vec(1'b0, 2'b00, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00,
         idle_o, "idle2"));

      chk8("mem5", mem[5], 8'hA7);
      chk8("mem2", mem[2], 8'h3C);
      chk8("mem6", mem[6], 8'h99);
      chk8("mem3", mem[3], 8'hC3);

      // Reset pulsed mid-sweep at pointer 4.
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      sweep(4, "init_part");
      chk("init_ptr4", cur(),
          mk(1'b1, 2'b00, 3'd4, 8'h00, 1'b1, 1'b0, 1'b1));
      #2;
      Reset_n = 1'b0;
      #1;
      chk("async_rst_init", cur(), rst_o);
      tick();
      Reset_n = 1'b1;
      sweep(8, "init_restart");

      // Reset while an aux request has waited two cycles.
      for (int i = 0; i < 2; i++) begin
         apply(vec(1'b1, 2'b00, 3'd2, 8'h10 + 8'(i),
                   1'b1, 3'd1, 8'h5A,
                   mk(1'b1, 2'b00, 3'd2, 8'h10 + 8'(i),
                      1'b0, 1'b0, 1'b0), "pend_core"));
      end
      #1;
      Reset_n = 1'b0;
      bus.CoreWe = 1'b0;
      #1;
      chk("async_rst_pend", cur(), rst_o);
      tick();
      Reset_n = 1'b1;
      sweep(8, "init_aux_held");
      apply(vec(1'b0, 2'b00, 3'd0, 8'h00, 1'b1, 3'd1, 8'h5A,
         mk(1'b1, 2'b00, 3'd1, 8'h5A, 1'b0, 1'b1, 1'b0),
         "aux_represent"));
      apply(vec(1'b0, 2'b00, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00,
         idle_o, "idle3"));

      chk8("mem1_aux", mem[1], 8'h5A);
      chk8("mem5_wiped", mem[5], 8'h00);
      chk8("mem2_wiped", mem[2], 8'h00);

      @(negedge Clk);
      #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d entries expected 0",
                  sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
